cpu_run_ctrl: RTL and testbench

Run/step/breakpoint sequencer for the 8-bit RISC CPU datapath. It gates the instruction-rate clock-enable tick from the ClkDiv into the single CpuCen pulse that the program counter, register file and output registers consume. It supports free-run from a switch, single-step from a pushbutton, and halt on a programmable PC breakpoint. Sits at the top level between the ClkDiv instance and every CPU-state register.

---
 rtl/cpu_run_ctrl.sv | 142 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer: turns the ClkDiv instruction tick into the
// single-cycle CpuCen pulse consumed by every CPU-state register.
`timescale 1ns/1ps
module cpu_run_ctrl #(
  parameter logic [15:0] DEB_CYCLES   = 16'd50000,
  parameter bit          RUN_ON_RESET = 1'b0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Cen,
  input  logic        RunSw,
  input  logic        StepBtn,
  input  logic        BrkEn,
  input  logic [7:0]  BrkAddr,
  input  logic [7:0]  PC,
  output logic        CpuCen,
  output logic [1:0]  State,
  output logic        Halted,
  output logic [15:0] CycleCnt
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_BRK  = 2'b11
  } state_t;

  state_t           state;
  logic             run_s1;
  logic             run_sync;
  logic             step_s1;
  logic             step_sync;
  logic [CNT_W-1:0] deb_cnt;
  logic             deb_level;
  logic             step_req;
  logic             armed;
  logic             brk_hit_c;

  assign State = state;

  // Two-flop synchronizers for both asynchronous user inputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      run_s1    <= 1'b0;
      run_sync  <= 1'b0;
      step_s1   <= 1'b0;
      step_sync <= 1'b0;
    end else begin
      run_s1    <= RunSw;
      run_sync  <= run_s1;
      step_s1   <= StepBtn;
      step_sync <= step_s1;
    end
  end

  // Debounce: accept a new level after DEB_CYCLES consecutive differing cycles;
  // step_req fires on the accepted 0->1 edge only.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
      step_req  <= 1'b0;
    end else begin
      step_req <= 1'b0;
      if (step_sync != deb_level) begin
        if ((17'(deb_cnt) + 17'd1) >= 17'(DEB_CYCLES)) begin
          deb_level <= step_sync;
          deb_cnt   <= '0;
          step_req  <= step_sync;
        end else begin
          deb_cnt <= deb_cnt + CNT_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // armed keeps a resumed run from re-hitting the breakpoint it stopped on
  assign brk_hit_c = BrkEn && armed && (PC == BrkAddr);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= RUN_ON_RESET ? ST_RUN : ST_HALT;
      Halted   <= !RUN_ON_RESET;
      CpuCen   <= 1'b0;
      CycleCnt <= '0;
      armed    <= 1'b0;
    end else begin
      CpuCen <= 1'b0;
      case (state)
        ST_HALT: begin
          if (run_sync) begin
            state  <= ST_RUN;
            Halted <= 1'b0;
            armed  <= 1'b0;
          end else if (step_req) begin
            state  <= ST_STEP;
            Halted <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!run_sync) begin
            state  <= ST_HALT;
            Halted <= 1'b1;
          end else if (Cen) begin
            if (brk_hit_c) begin
              state  <= ST_BRK;
              Halted <= 1'b1;
            end else begin
              CpuCen   <= 1'b1;
              CycleCnt <= CycleCnt + CNT_W'(1);
              armed    <= 1'b1;
            end
          end
        end
        ST_STEP: begin
          if (Cen) begin
            CpuCen   <= 1'b1;
            CycleCnt <= CycleCnt + CNT_W'(1);
            state    <= ST_HALT;
            Halted   <= 1'b1;
          end
        end
        ST_BRK: begin
          // Resuming to RUN must pass through HALT (switch fall then rise)
          if (!run_sync) begin
            state  <= ST_HALT;
            Halted <= 1'b1;
          end else if (step_req) begin
            state  <= ST_STEP;
            Halted <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: stimulus queues expected pulses, a
// negedge monitor pops and checks each CpuCen pulse's cycle and CycleCnt.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Cen;
  logic        RunSw;
  logic        StepBtn;
  logic        BrkEn;
  logic [7:0]  BrkAddr;
  logic [7:0]  PC;
  logic        CpuCen;
  logic [1:0]  State;
  logic        Halted;
  logic [15:0] CycleCnt;

  cpu_run_ctrl #(.DEB_CYCLES(16'd4), .RUN_ON_RESET(1'b0)) dut (
    .Clk(Clk), .Rst(Rst), .Cen(Cen), .RunSw(RunSw), .StepBtn(StepBtn),
    .BrkEn(BrkEn), .BrkAddr(BrkAddr), .PC(PC), .CpuCen(CpuCen),
    .State(State), .Halted(Halted), .CycleCnt(CycleCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned cyc;
    logic [15:0] cnt;
  } pulse_t;

  pulse_t      sb[$];
  int unsigned cyc_n = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt;

  always @(posedge Clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic check_st(input string name, input logic [1:0] st, input logic h);
    check({name, "_state"}, 32'(State), 32'(st));
    check({name, "_halted"}, 32'(Halted), 32'(h));
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // One-cycle Cen tick; queue the pulse expected on the following cycle
  task automatic cen_tick(input bit pulse);
    pulse_t p;
    Cen = 1'b1;
    if (pulse) begin
      exp_cnt = exp_cnt + 16'd1;
      p.cyc = cyc_n + 1;
      p.cnt = exp_cnt;
      sb.push_back(p);
    end
    cyc(1);
    Cen = 1'b0;
  endtask

  task automatic wait_state(input string name, input logic [1:0] want, input int budget);
    int k = 0;
    while (State !== want && k < budget) begin
      cyc(1);
      k++;
    end
    check(name, 32'(State), 32'(want));
  endtask

  always @(negedge Clk) begin
    pulse_t p;
    if (CpuCen === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: CpuCen=1 at cycle %0d, required no pulse", cyc_n);
      end else begin
        p = sb.pop_front();
        check("pulse_cycle", 32'(cyc_n), 32'(p.cyc));
        check("pulse_count", 32'(CycleCnt), 32'(p.cnt));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_step;
    Rst = 1'b1; Cen = 1'b0; RunSw = 1'b0; StepBtn = 1'b0;
    BrkEn = 1'b0; BrkAddr = 8'h00; PC = 8'h00; exp_cnt = 16'h0000;

    // Reset state and no pulses while halted
    cyc(3);
    Rst = 1'b0;
    cyc(1);
    check_st("reset", 2'b00, 1'b1);
    check("reset_cpucen", 32'(CpuCen), 32'd0);
    check("reset_cyclecnt", 32'(CycleCnt), 32'd0);
    repeat (10) begin
      cen_tick(1'b0);
      cyc(4);
    end
    check_st("halt_ticks", 2'b00, 1'b1);

    // Bouncy step press yields exactly one step
    for (int i = 0; i < 4; i++) begin
      StepBtn = (i % 2 == 0);
      cyc(1);
    end
    StepBtn = 1'b1;
    cyc(6);
    StepBtn = 1'b0;
    wait_state("step_entry", 2'b10, 20);
    check("step_halted", 32'(Halted), 32'd0);
    cyc(3);
    check("step_waits_cen", 32'(State), 32'd2);
    cen_tick(1'b1);
    check_st("step_done", 2'b00, 1'b1);
    cyc(20);
    check("single_stepreq", 32'(State), 32'd0);
    check("step_cyclecnt", 32'(CycleCnt), 32'd1);

    // Free run, then stop coinciding with a Cen tick
    RunSw = 1'b1;
    wait_state("run_entry", 2'b01, 10);
    check("run_halted", 32'(Halted), 32'd0);
    repeat (20) begin
      cen_tick(1'b1);
      cyc(9);
    end
    check("run_cyclecnt", 32'(CycleCnt), 32'd21);
    RunSw = 1'b0;
    cyc(2);
    cen_tick(1'b0);
    check_st("run_stop", 2'b00, 1'b1);

    // Breakpoint at PC=05, then single step out of BRK
    BrkEn = 1'b1; BrkAddr = 8'h05; PC = 8'h00;
    RunSw = 1'b1;
    wait_state("brk_run_entry", 2'b01, 10);
    for (int pc = 0; pc < 5; pc++) begin
      PC = 8'(pc);
      cen_tick(1'b1);
      cyc(3);
    end
    PC = 8'h05;
    cen_tick(1'b0);
    check_st("brk_hit", 2'b11, 1'b1);
    cyc(3);
    cen_tick(1'b0);
    check_st("brk_hold", 2'b11, 1'b1);
    StepBtn = 1'b1;
    cyc(6);
    StepBtn = 1'b0;
    wait_state("brk_step_entry", 2'b10, 20);
    cen_tick(1'b1);
    check_st("brk_step_done", 2'b00, 1'b1);
    PC = 8'h06;
    cyc(1);
    check("brk_step_rerun", 32'(State), 32'd1);
    RunSw = 1'b0;
    wait_state("brk_stop", 2'b00, 10);
    cyc(10);

    // Resume from breakpoint executes BrkAddr, then re-arms
    RunSw = 1'b1;
    wait_state("res_run1", 2'b01, 10);
    PC = 8'h04;
    cen_tick(1'b1);
    cyc(2);
    PC = 8'h05;
    cen_tick(1'b0);
    check_st("res_brk1", 2'b11, 1'b1);
    RunSw = 1'b0;
    wait_state("res_halt", 2'b00, 10);
    RunSw = 1'b1;
    wait_state("res_run2", 2'b01, 10);
    cen_tick(1'b1);
    check_st("res_exec_brk", 2'b01, 1'b0);
    cyc(2);
    PC = 8'h06;
    cen_tick(1'b1);
    cyc(2);
    PC = 8'h05;
    cen_tick(1'b0);
    check_st("res_rearm", 2'b11, 1'b1);

    // CycleCnt wrap
    RunSw = 1'b0;
    wait_state("wrap_halt", 2'b00, 10);
    BrkEn = 1'b0;
    RunSw = 1'b1;
    wait_state("wrap_run", 2'b01, 10);
    Cen = 1'b1;
    while (exp_cnt != 16'hFFFF) begin
      pulse_t p;
      exp_cnt = exp_cnt + 16'd1;
      p.cyc = cyc_n + 1;
      p.cnt = exp_cnt;
      sb.push_back(p);
      cyc(1);
    end
    Cen = 1'b0;
    cyc(1);
    check("wrap_ffff", 32'(CycleCnt), 32'h0000FFFF);
    cen_tick(1'b1);
    cyc(1);
    check("wrap_zero", 32'(CycleCnt), 32'h00000000);

    // StepReq and RunSw rising together in HALT: RUN wins
    RunSw = 1'b0;
    wait_state("tie_halt", 2'b00, 10);
    cyc(5);
    StepBtn = 1'b1;
    cyc(4);
    RunSw = 1'b1;
    saw_step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (State == 2'b10) saw_step = 1'b1;
    end
    check("tie_no_step", 32'(saw_step), 32'd0);
    check_st("tie_run", 2'b01, 1'b0);
    StepBtn = 1'b0;
    cyc(10);

    // Reset during STEP cancels the pending pulse
    RunSw = 1'b0;
    wait_state("rst_halt", 2'b00, 10);
    StepBtn = 1'b1;
    cyc(6);
    StepBtn = 1'b0;
    wait_state("rst_step_entry", 2'b10, 20);
    Rst = 1'b1;
    Cen = 1'b1;
    cyc(1);
    Rst = 1'b0;
    Cen = 1'b0;
    exp_cnt = 16'h0000;
    check("rst_cpucen", 32'(CpuCen), 32'd0);
    check_st("rst_mid_step", 2'b00, 1'b1);
    check("rst_cyclecnt", 32'(CycleCnt), 32'd0);
    cyc(5);
    check("rst_still_halt", 32'(State), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
